// File: rtl/sha_hit_detector.sv
// sha_hit_detector: tags each double-hash result from the SHA core with its
// sequential nonce, compares the Bitcoin-order digest value against the
// target, queues winning nonces in a show-ahead FIFO and keeps per-job
// status (overflow, nonce wrap, saturating hit count).
// doublehash carries H0 in bits [255:224] down to H7 in bits [31:0].
module sha_hit_detector #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned HITCNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                hash_valid,
   input  logic [255:0]        doublehash,
   input  logic                job_load,
   input  logic [31:0]         start_nonce,
   input  logic [255:0]        target,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_nonce,
   output logic                overflow,
   output logic                nonce_wrapped,
   output logic [HITCNT_W-1:0] hit_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned FILL_W = PTR_W + 1;
   localparam logic [FILL_W-1:0] DEPTH_C = FILL_W'(FIFO_DEPTH);

   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   logic [31:0]         cnt;
   logic [31:0]         tag;
   logic [255:0]        value;
   logic                hit_now;
   logic                wrap_now;

   logic                s1_valid;
   logic                s1_hit;
   logic [31:0]         s1_tag;

   logic [31:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [FILL_W-1:0]   fill;
   logic                push;
   logic                pop;
   logic                full;
   logic                accept;
   logic                drop;
   logic [HITCNT_W-1:0] hc_base;
   logic [HITCNT_W-1:0] hc_next;

   // Cycle 0: pick the nonce tag, form the little-endian digest value, compare.
   always_comb begin
      tag   = job_load ? start_nonce : cnt;
      value = '0;
      for (int unsigned w = 0; w < 8; w++) begin
         value[32*w +: 32] = bswap(doublehash[255-32*w -: 32]);
      end
      hit_now  = (value <= target);
      wrap_now = hash_valid && (tag == '1);
   end

   // Nonce counter and stage-1 pipeline registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         s1_valid <= 1'b0;
         s1_hit   <= 1'b0;
         s1_tag   <= '0;
      end else begin
         if (hash_valid) begin
            cnt <= tag + 32'd1;
         end else if (job_load) begin
            cnt <= start_nonce;
         end
         s1_valid <= hash_valid;
         s1_hit   <= hit_now;
         s1_tag   <= tag;
      end
   end

   // Stage 2 push/pop decisions and next hit count; a full FIFO still
   // accepts a push when the head is popped on the same edge.
   always_comb begin
      push      = s1_valid && s1_hit;
      full      = (fill == DEPTH_C);
      out_valid = (fill != '0);
      pop       = out_valid && out_ready;
      accept    = push && (!full || pop);
      drop      = push && full && !pop;
      out_nonce = out_valid ? mem[rd_ptr] : '0;
      hc_base   = job_load ? '0 : hit_count;
      hc_next   = hc_base;
      if (push && (hc_base != '1)) begin
         hc_next = hc_base + 1'b1;
      end
   end

   // FIFO storage; contents are only meaningful below the fill level.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= s1_tag;
      end
   end

   // FIFO pointers and fill level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // Per-job status: job_load clears, same-edge events land on top.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow      <= 1'b0;
         nonce_wrapped <= 1'b0;
         hit_count     <= '0;
      end else begin
         if (job_load) begin
            overflow      <= drop;
            nonce_wrapped <= wrap_now;
         end else begin
            overflow      <= overflow | drop;
            nonce_wrapped <= nonce_wrapped | wrap_now;
         end
         hit_count <= hc_next;
      end
   end

endmodule

// File: tb/tb_sha_hit_detector.sv
// Testbench for sha_hit_detector: directed scenarios plus a random phase,
// with a behavioural reference model feeding an expected-nonce scoreboard.
module tb_sha_hit_detector;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned HC_W  = 5;
   localparam int          HC_MAX = (1 << HC_W) - 1;

   logic            clk;
   logic            rst;
   logic            hash_valid;
   logic [255:0]    doublehash;
   logic            job_load;
   logic [31:0]     start_nonce;
   logic [255:0]    target;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_nonce;
   logic            overflow;
   logic            nonce_wrapped;
   logic [HC_W-1:0] hit_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [31:0] exp_q[$];
   logic [31:0] m_cnt;
   logic [31:0] m_s1_tag;
   bit          m_s1_hit;
   int          m_occ;
   bit          m_ovf;
   bit          m_wrap;
   int          m_hc;

   sha_hit_detector #(.FIFO_DEPTH(DEPTH), .HITCNT_W(HC_W)) dut (
      .clk(clk), .rst(rst), .hash_valid(hash_valid), .doublehash(doublehash),
      .job_load(job_load), .start_nonce(start_nonce), .target(target),
      .out_valid(out_valid), .out_ready(out_ready), .out_nonce(out_nonce),
      .overflow(overflow), .nonce_wrapped(nonce_wrapped), .hit_count(hit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Digest bytes read as a little-endian 256-bit integer.
   function automatic logic [255:0] le_value(input logic [255:0] d);
      logic [255:0] v = '0;
      for (int i = 0; i < 32; i++) v[8*i +: 8] = d[255-8*i -: 8];
      return v;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Reference model: advances once per clock edge using the inputs held
   // through that edge; accepted hits go onto the scoreboard queue.
   always @(posedge clk) begin
      if (!rst) begin
         m_cnt = 0; m_s1_tag = 0; m_s1_hit = 0; m_occ = 0;
         m_ovf = 0; m_wrap = 0; m_hc = 0;
         exp_q.delete();
      end else begin
         bit pop;
         logic [31:0] tg;
         pop = (m_occ > 0) && out_ready;
         tg  = job_load ? start_nonce : m_cnt;
         if (job_load) begin m_ovf = 0; m_wrap = 0; m_hc = 0; end
         if (m_s1_hit) begin
            if (m_hc < HC_MAX) m_hc++;
            if (m_occ == DEPTH && !pop) m_ovf = 1;
            else begin exp_q.push_back(m_s1_tag); m_occ++; end
         end
         if (pop) m_occ--;
         if (hash_valid && tg == 32'hFFFF_FFFF) m_wrap = 1;
         m_s1_hit = hash_valid && (le_value(doublehash) <= target);
         m_s1_tag = tg;
         if (hash_valid) m_cnt = tg + 1;
         else if (job_load) m_cnt = start_nonce;
      end
   end

   // Monitor: compares DUT outputs against the model away from the clock edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_out_nonce", out_nonce, 0);
         chk("rst_overflow", 32'(overflow), 0);
         chk("rst_nonce_wrapped", 32'(nonce_wrapped), 0);
         chk("rst_hit_count", 32'(hit_count), 0);
      end else begin
         chk("out_valid", 32'(out_valid), 32'(m_occ != 0));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("nonce_wrapped", 32'(nonce_wrapped), 32'(m_wrap));
         chk("hit_count", 32'(hit_count), 32'(m_hc));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL out_nonce: got %h expected no output", out_nonce);
            end else begin
               chk("out_nonce", out_nonce, exp_q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic hash(input logic [255:0] d, input logic jl, input logic [31:0] sn);
      hash_valid = 1; doublehash = d; job_load = jl; start_nonce = sn;
      step();
      hash_valid = 0; job_load = 0;
   endtask

   task automatic idle(input int n);
      hash_valid = 0; job_load = 0;
      repeat (n) step();
   endtask

   task automatic drain();
      idle(3);
      out_ready = 1;
      for (int i = 0; i < 40 && out_valid; i++) step();
      chk("drain_empty", 32'(out_valid), 0);
   endtask

   initial begin
      logic [255:0] d0;
      logic [255:0] v0;
      logic [31:0]  sn;
      rst = 1; hash_valid = 0; doublehash = '0; job_load = 0; start_nonce = 0;
      target = '1; out_ready = 0;
      #1 rst = 0;

      // T1: reset held with random inputs, then released
      for (int i = 0; i < 5; i++) begin
         hash_valid = 1'($urandom); job_load = 1'($urandom); out_ready = 1'($urandom);
         doublehash = rand256(); start_nonce = $urandom; target = '1;
         step();
      end
      idle(1);
      out_ready = 0;
      rst = 1;
      idle(3);
      chk("t1_out_valid", 32'(out_valid), 0);
      chk("t1_hit_count", 32'(hit_count), 0);

      // T2: tagging and latency
      target = '1; out_ready = 1;
      for (int i = 0; i < 8; i++) hash(rand256(), i == 0, 32'h10);
      idle(4);
      chk("t2_hit_count", 32'(hit_count), 8);
      drain();

      // T3: compare boundary and digest byte order
      d0 = rand256();
      v0 = le_value(d0);
      job_load = 1; start_nonce = 32'h100; step(); job_load = 0;
      target = v0;      hash(d0, 0, 0); idle(3);
      chk("t3_equal_hits", 32'(hit_count), 1);
      target = v0 - 1;  hash(d0, 0, 0); idle(3);
      chk("t3_below_misses", 32'(hit_count), 1);
      target = 256'hFF << 240;
      hash(256'hFF00_0000, 0, 0); idle(3);
      chk("t3_h7_msb_hits", 32'(hit_count), 2);
      hash(256'h0000_00FF, 0, 0); idle(3);
      chk("t3_h7_lsb_misses", 32'(hit_count), 2);
      drain();

      // T4: FIFO full, drops, then simultaneous push and pop while full
      target = '1; out_ready = 0;
      for (int i = 0; i < 6; i++) hash(rand256(), i == 0, 32'h200);
      idle(3);
      chk("t4_overflow", 32'(overflow), 1);
      chk("t4_hit_count", 32'(hit_count), 6);
      chk("t4_head", out_nonce, 32'h200);
      hash(rand256(), 0, 0);
      out_ready = 1;
      step();
      chk("t4_push_pop_count", 32'(hit_count), 7);
      drain();

      // T5: nonce wrap and job_load coincident with a hash
      target = '1;
      hash(rand256(), 1, 32'hFFFF_FFFE);
      hash(rand256(), 0, 0);
      hash(rand256(), 0, 0);
      idle(3);
      chk("t5_wrapped", 32'(nonce_wrapped), 1);
      chk("t5_hit_count", 32'(hit_count), 3);
      hash(rand256(), 1, 32'h1234);
      chk("t5_wrap_cleared", 32'(nonce_wrapped), 0);
      chk("t5_count_cleared", 32'(hit_count), 0);
      idle(3);
      chk("t5_new_job_count", 32'(hit_count), 1);
      drain();

      // T6: bubbles keep nonces contiguous; reset discards queued hits
      sn = $urandom;
      for (int i = 0; i < 8; i++) begin
         hash(rand256(), i == 0, sn);
         idle(1);
      end
      drain();
      out_ready = 0;
      hash(rand256(), 0, 0); hash(rand256(), 0, 0); idle(3);
      chk("t6_queued", 32'(out_valid), 1);
      rst = 0;
      #1;
      chk("t6_reset_out_valid", 32'(out_valid), 0);
      chk("t6_reset_out_nonce", out_nonce, 0);
      idle(2);
      rst = 1;
      idle(1);
      hash(rand256(), 0, 0);
      step();
      chk("t6_counter_restart", out_nonce, 0);
      drain();

      // Random phase
      for (int i = 0; i < 600; i++) begin
         hash_valid = ($urandom_range(0, 3) != 0);
         job_load   = ($urandom_range(0, 15) == 0);
         start_nonce = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
         doublehash = rand256();
         case ($urandom_range(0, 3))
            0, 1: target = '1;
            2:    target = rand256();
            default: target = le_value(doublehash);
         endcase
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
